// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory.
// Ports: A = CPU mem port, B = loader/DMA with bus lock;
//   mem_* drives a sync-read memory; x_rvalid_o/x_rdata_o
//   return read data to the issuer one cycle after grant.
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int CPU_PRIO = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_gnt_o,
   output logic              a_stall_o,
   output logic              a_rvalid_o,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_req_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   input  logic              b_lock_i,
   output logic              b_gnt_o,
   output logic              b_rvalid_o,
   output logic [DATA_W-1:0] b_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              locked_o,
   output logic              owner_o
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

   typedef enum logic {ARB, LOCK_B} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [WW-1:0] b_wait;
   logic          owner_q;
   logic          resp_owner;
   logic          resp_rd;
   logic          a_gnt;
   logic          b_gnt;
   logic          b_win;

   // On a tie: fixed priority with a starvation escape for B,
   // or round-robin against the last owner.
   always_comb begin
      b_win = (CPU_PRIO != 0) ? (b_wait == WMAX) : ~owner_q;
   end

   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      unique case (state)
         ARB: begin
            unique case (1'b1)
               a_req_i & ~b_req_i: a_gnt = 1'b1;
               ~a_req_i & b_req_i: b_gnt = 1'b1;
               a_req_i & b_req_i: begin
                  a_gnt = ~b_win;
                  b_gnt = b_win;
               end
               default: ;
            endcase
            if (b_gnt && b_lock_i) state_nxt = LOCK_B;
         end
         LOCK_B: begin
            b_gnt = b_req_i;
            if (!b_lock_i) state_nxt = ARB;
         end
      endcase
   end

   // Grants are masked while reset is held low.
   assign a_gnt_o   = a_gnt & reset;
   assign b_gnt_o   = b_gnt & reset;
   assign a_stall_o = a_req_i & ~a_gnt_o;
   assign mem_en_o  = a_gnt_o | b_gnt_o;

   assign mem_we_o    = (a_gnt_o & a_we_i) | (b_gnt_o & b_we_i);
   assign mem_addr_o  = ({ADDR_W{a_gnt_o}} & a_addr_i)
                      | ({ADDR_W{b_gnt_o}} & b_addr_i);
   assign mem_wdata_o = ({DATA_W{a_gnt_o}} & a_wdata_i)
                      | ({DATA_W{b_gnt_o}} & b_wdata_i);

   assign a_rdata_o  = mem_rdata_i;
   assign b_rdata_o  = mem_rdata_i;
   assign a_rvalid_o = resp_rd & ~resp_owner;
   assign b_rvalid_o = resp_rd & resp_owner;
   assign locked_o   = (state == LOCK_B);
   assign owner_o    = owner_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB;
         owner_q    <= 1'b1;
         b_wait     <= '0;
         resp_owner <= 1'b0;
         resp_rd    <= 1'b0;
      end else begin
         state   <= state_nxt;
         resp_rd <= mem_en_o & ~mem_we_o;
         if (mem_en_o) begin
            owner_q    <= b_gnt_o;
            resp_owner <= b_gnt_o;
         end
         if (b_gnt_o) begin
            b_wait <= '0;
         end else if (state == ARB && b_req_i && b_wait != WMAX) begin
            b_wait <= b_wait + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one fixed-priority and one
// round-robin instance share stimulus; sel picks the checked one.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we, b_lock;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        sel;

   logic        p_a_gnt, p_a_stall, p_a_rvalid, p_b_gnt, p_b_rvalid;
   logic        p_mem_en, p_mem_we, p_locked, p_owner;
   logic [31:0] p_a_rdata, p_b_rdata, p_mem_addr, p_mem_wdata, p_mrd;
   logic        r_a_gnt, r_a_stall, r_a_rvalid, r_b_gnt, r_b_rvalid;
   logic        r_mem_en, r_mem_we, r_locked, r_owner;
   logic [31:0] r_a_rdata, r_b_rdata, r_mem_addr, r_mem_wdata, r_mrd;

   logic [31:0] pm [64];
   logic [31:0] rm [64];

   typedef struct {
      logic        port;
      logic [31:0] data;
   } rsp_t;
   rsp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.CPU_PRIO(1), .MAX_WAIT(4)) u_prio (
      .clk(clk), .reset(reset),
      .a_req_i(a_req), .a_we_i(a_we),
      .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_gnt_o(p_a_gnt), .a_stall_o(p_a_stall),
      .a_rvalid_o(p_a_rvalid), .a_rdata_o(p_a_rdata),
      .b_req_i(b_req), .b_we_i(b_we),
      .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_lock_i(b_lock), .b_gnt_o(p_b_gnt),
      .b_rvalid_o(p_b_rvalid), .b_rdata_o(p_b_rdata),
      .mem_en_o(p_mem_en), .mem_we_o(p_mem_we),
      .mem_addr_o(p_mem_addr), .mem_wdata_o(p_mem_wdata),
      .mem_rdata_i(p_mrd),
      .locked_o(p_locked), .owner_o(p_owner)
   );

   mem_arbiter #(.CPU_PRIO(0), .MAX_WAIT(4)) u_rr (
      .clk(clk), .reset(reset),
      .a_req_i(a_req), .a_we_i(a_we),
      .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_gnt_o(r_a_gnt), .a_stall_o(r_a_stall),
      .a_rvalid_o(r_a_rvalid), .a_rdata_o(r_a_rdata),
      .b_req_i(b_req), .b_we_i(b_we),
      .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_lock_i(b_lock), .b_gnt_o(r_b_gnt),
      .b_rvalid_o(r_b_rvalid), .b_rdata_o(r_b_rdata),
      .mem_en_o(r_mem_en), .mem_we_o(r_mem_we),
      .mem_addr_o(r_mem_addr), .mem_wdata_o(r_mem_wdata),
      .mem_rdata_i(r_mrd),
      .locked_o(r_locked), .owner_o(r_owner)
   );

   // Sync-read memories; known words reloaded while reset is low.
   always @(posedge clk) begin
      if (!reset) begin
         pm[0] <= 32'hFFFF_FFFF;
         pm[1] <= 32'hFFFF_FFFF;
         pm[2] <= 32'hFFFF_FFFF;
         pm[4] <= 32'hDEAD_BEEF;
         pm[5] <= 32'hB0B0_0014;
         pm[8] <= 32'hC0DE_0020;
      end else if (p_mem_en) begin
         if (p_mem_we) pm[p_mem_addr[7:2]] <= p_mem_wdata;
         else          p_mrd <= pm[p_mem_addr[7:2]];
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         rm[0] <= 32'hFFFF_FFFF;
         rm[1] <= 32'hFFFF_FFFF;
         rm[2] <= 32'hFFFF_FFFF;
         rm[4] <= 32'hDEAD_BEEF;
         rm[5] <= 32'hB0B0_0014;
         rm[8] <= 32'hC0DE_0020;
      end else if (r_mem_en) begin
         if (r_mem_we) rm[r_mem_addr[7:2]] <= r_mem_wdata;
         else          r_mrd <= rm[r_mem_addr[7:2]];
      end
   end

   logic        c_a_gnt, c_a_stall, c_a_rvalid;
   logic        c_b_gnt, c_b_rvalid;
   logic        c_mem_en, c_mem_we, c_locked, c_owner;
   logic [31:0] c_a_rdata, c_b_rdata, c_mem_addr, c_mem_wdata;

   assign c_a_gnt     = sel ? r_a_gnt     : p_a_gnt;
   assign c_a_stall   = sel ? r_a_stall   : p_a_stall;
   assign c_a_rvalid  = sel ? r_a_rvalid  : p_a_rvalid;
   assign c_b_gnt     = sel ? r_b_gnt     : p_b_gnt;
   assign c_b_rvalid  = sel ? r_b_rvalid  : p_b_rvalid;
   assign c_mem_en    = sel ? r_mem_en    : p_mem_en;
   assign c_mem_we    = sel ? r_mem_we    : p_mem_we;
   assign c_locked    = sel ? r_locked    : p_locked;
   assign c_owner     = sel ? r_owner     : p_owner;
   assign c_a_rdata   = sel ? r_a_rdata   : p_a_rdata;
   assign c_b_rdata   = sel ? r_b_rdata   : p_b_rdata;
   assign c_mem_addr  = sel ? r_mem_addr  : p_mem_addr;
   assign c_mem_wdata = sel ? r_mem_wdata : p_mem_wdata;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic gnt_chk(input string tag,
                          input logic ea, input logic eb);
      chk({tag, "_a_gnt"}, {31'd0, c_a_gnt}, {31'd0, ea});
      chk({tag, "_b_gnt"}, {31'd0, c_b_gnt}, {31'd0, eb});
      chk({tag, "_en"}, {31'd0, c_mem_en}, {31'd0, ea | eb});
   endtask

   task automatic push(input logic port, input logic [31:0] d);
      rsp_t e;
      e.port = port;
      e.data = d;
      q.push_back(e);
   endtask

   // Compare this cycle's read response against the scoreboard.
   task automatic resp_chk();
      rsp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("rv_a", {31'd0, c_a_rvalid}, {31'd0, ~e.port});
         chk("rv_b", {31'd0, c_b_rvalid}, {31'd0, e.port});
         chk("rdata", e.port ? c_b_rdata : c_a_rdata, e.data);
      end else begin
         chk("rv_a_none", {31'd0, c_a_rvalid}, 32'd0);
         chk("rv_b_none", {31'd0, c_b_rvalid}, 32'd0);
      end
   endtask

   task automatic cyc(input logic ar, input logic aw,
                      input logic [31:0] aad, input logic [31:0] awd,
                      input logic br, input logic bw,
                      input logic [31:0] bad, input logic [31:0] bwd,
                      input logic bl);
      @(negedge clk);
      a_req = ar; a_we = aw; a_addr = aad; a_wdata = awd;
      b_req = br; b_we = bw; b_addr = bad; b_wdata = bwd;
      b_lock = bl;
      #2;
      resp_chk();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      b_lock = 0;
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic eb;
      sel = 1'b0;
      reset = 1'b0;
      a_req = 1; a_we = 0; a_addr = 32'h10; a_wdata = 0;
      b_req = 1; b_we = 0; b_addr = 32'h14; b_wdata = 0;
      b_lock = 1;

      // Reset state with requests present.
      @(negedge clk); #2;
      gnt_chk("rst", 0, 0);
      chk("rst_we", {31'd0, c_mem_we}, 32'd0);
      chk("rst_owner", {31'd0, c_owner}, 32'd1);
      chk("rst_lock", {31'd0, c_locked}, 32'd0);
      resp_chk();
      @(negedge clk);
      reset = 1'b1;
      a_req = 0; b_req = 0; b_lock = 0;

      // A-only read.
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      gnt_chk("aread", 1, 0);
      chk("aread_addr", c_mem_addr, 32'h10);
      chk("aread_we", {31'd0, c_mem_we}, 32'd0);
      push(0, 32'hDEAD_BEEF);

      // Fixed priority with starvation limit 4.
      for (int i = 0; i < 10; i++) begin
         eb = (i % 5 == 4);
         cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
         gnt_chk($sformatf("prio%0d", i), ~eb, eb);
         chk($sformatf("prio%0d_stall", i),
             {31'd0, c_a_stall}, {31'd0, eb});
         chk($sformatf("prio%0d_addr", i), c_mem_addr,
             eb ? 32'h14 : 32'h10);
         push(eb, eb ? 32'hB0B0_0014 : 32'hDEAD_BEEF);
      end

      // Idle and write.
      idle();
      gnt_chk("idle0", 0, 0);
      chk("idle0_addr", c_mem_addr, 32'd0);
      chk("idle0_owner", {31'd0, c_owner}, 32'd1);
      cyc(1, 1, 32'h30, 32'h1234_5678, 0, 0, 0, 0, 0);
      gnt_chk("wr", 1, 0);
      chk("wr_we", {31'd0, c_mem_we}, 32'd1);
      chk("wr_data", c_mem_wdata, 32'h1234_5678);
      idle();
      gnt_chk("idle1", 0, 0);
      chk("idle1_owner", {31'd0, c_owner}, 32'd0);
      chk("wr_mem", pm[12], 32'h1234_5678);
      idle();
      chk("idle2_owner", {31'd0, c_owner}, 32'd0);

      // Round-robin from reset.
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         eb = (i % 2 == 1);
         cyc(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
         gnt_chk($sformatf("rr%0d", i), ~eb, eb);
         chk($sformatf("rr%0d_owner", i), {31'd0, c_owner},
             (i == 0) ? 32'd1 : 32'((i - 1) % 2));
         push(eb, eb ? 32'hB0B0_0014 : 32'hDEAD_BEEF);
      end

      // B lock burst with A requesting throughout.
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h0, 32'h1111_0000, 1);
      gnt_chk("lk0", 1, 0);
      push(0, 32'hDEAD_BEEF);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h0, 32'h1111_0000, 1);
      gnt_chk("lk1", 0, 1);
      chk("lk1_stall", {31'd0, c_a_stall}, 32'd1);
      chk("lk1_lock", {31'd0, c_locked}, 32'd0);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h4, 32'h2222_0004, 1);
      gnt_chk("lk2", 0, 1);
      chk("lk2_lock", {31'd0, c_locked}, 32'd1);
      cyc(1, 0, 32'h10, 0, 1, 1, 32'h8, 32'h3333_0008, 1);
      gnt_chk("lk3", 0, 1);
      chk("lk3_lock", {31'd0, c_locked}, 32'd1);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      gnt_chk("lk4", 0, 0);
      chk("lk4_lock", {31'd0, c_locked}, 32'd1);
      cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      gnt_chk("lk5", 1, 0);
      chk("lk5_lock", {31'd0, c_locked}, 32'd0);
      push(0, 32'hDEAD_BEEF);
      chk("lk_mem0", rm[0], 32'h1111_0000);
      chk("lk_mem1", rm[1], 32'h2222_0004);
      chk("lk_mem2", rm[2], 32'h3333_0008);

      // Reset in LOCK_B with a read response in flight.
      cyc(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 1);
      gnt_chk("ml0", 0, 1);
      push(1, 32'hC0DE_0020);
      @(negedge clk); #1;
      resp_chk();
      chk("ml1_lock", {31'd0, c_locked}, 32'd1);
      reset = 1'b0;
      #1;
      q.delete();
      gnt_chk("mlr", 0, 0);
      chk("mlr_lock", {31'd0, c_locked}, 32'd0);
      chk("mlr_rva", {31'd0, c_a_rvalid}, 32'd0);
      chk("mlr_rvb", {31'd0, c_b_rvalid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      b_lock = 1'b0;
      #2;
      resp_chk();
      gnt_chk("post", 1, 0);
      push(0, 32'hDEAD_BEEF);
      idle();
      gnt_chk("end", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter for the single shared instruction/data memory of the multicycle RISC-V core. Port A is the processor's memory port (instruction fetch and load/store, one request per FSM memory state). Port B is the program loader / debug DMA. The block selects one request per cycle, drives the synchronous-read memory, and routes each read response back to its issuer one cycle later. It also provides a B-side bus lock for bursts and starvation protection for B.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CPU_PRIO, 1, 1 = A has fixed priority with B starvation limit; 0 = round-robin
MAX_WAIT, 4, in CPU_PRIO=1 mode, consecutive cycles B may be denied before B is forced to win (≥1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
a_req_i  input  1  A requests an access; A holds we/addr/wdata stable until granted
a_we_i  input  1  A write (1) / read (0)
a_addr_i  input  ADDR_W  A address
a_wdata_i  input  DATA_W  A write data
a_gnt_o  output  1  A access issued to memory this cycle
a_stall_o  output  1  a_req_i & ~a_gnt_o; holds the processor FSM in its current state
a_rvalid_o  output  1  A read data valid
a_rdata_o  output  DATA_W  A read data
b_req_i, b_we_i, b_addr_i, b_wdata_i  input  1/1/ADDR_W/DATA_W  B request, same rules as A
b_lock_i  input  1  B requests the bus be held after its grant
b_gnt_o  output  1  B access issued this cycle
b_rvalid_o  output  1  B read data valid
b_rdata_o  output  DATA_W  B read data
mem_en_o  output  1  memory access strobe
mem_we_o  output  1  memory write enable
mem_addr_o  output  ADDR_W  memory address
mem_wdata_o  output  DATA_W  memory write data
mem_rdata_i  input  DATA_W  memory read data, valid the cycle after mem_en_o with mem_we_o=0
locked_o  output  1  1 while in LOCK_B
owner_o  output  1  registered: 0 = A, 1 = B was the last granted requester

Behaviour:
- Grant path:
  - Grants are combinational from the requests and the current state.
  - At most one of a_gnt_o/b_gnt_o is 1.
  - mem_en_o = a_gnt_o | b_gnt_o.
  - mem_we_o, mem_addr_o and mem_wdata_o are muxed from the granted port, and are 0 when neither port is granted.
- Throughput: one access per cycle. Back-to-back grants are legal, including alternating owners.
- Read response:
  - Registered resp_owner and resp_rd capture (owner, ~we) at every grant.
  - Next cycle, the matching x_rvalid_o = 1 for exactly one cycle.
  - a_rdata_o = b_rdata_o = mem_rdata_i. They are only meaningful with their rvalid.
  - Writes produce no rvalid.
- FSM states:
  - ARB:
    - Only one request present → grant it.
    - Both requests, CPU_PRIO=1 → A wins unless b_wait == MAX_WAIT, then B wins.
    - Both requests, CPU_PRIO=0 → grant the requester that is not owner_o.
    - If B is granted and b_lock_i=1 → next state LOCK_B.
  - LOCK_B:
    - Only B can be granted; a_gnt_o=0 regardless of a_req_i.
    - b_lock_i=0 at the clock edge → next state ARB.
    - The cycle in which b_lock_i falls is still B-only.
- b_wait counter, saturating at MAX_WAIT:
  - Increments each cycle b_req_i=1 and b_gnt_o=0.
  - Clears on b_gnt_o.
  - Not incremented in LOCK_B.
- owner_o updates only on a grant. It holds when idle.
- Reset (reset=0, asynchronous):
  - state=ARB, owner_o=1 (so A wins the first round-robin tie), b_wait=0.
  - resp_owner=0, resp_rd=0, so all rvalid outputs are 0.
  - While reset is low, all gnt outputs and mem_en_o/mem_we_o are forced 0.
  - A reset during LOCK_B exits the lock immediately.
  - A read response pending at reset is dropped.
- Request changing before grant is a protocol violation; the design's behaviour for it is undefined.

Test Plan:
- A-only read: a_req_i=1, a_addr_i=0x10, memory holds 0xDEADBEEF there → a_gnt_o=1, mem_addr_o=0x10, mem_we_o=0 same cycle; next cycle a_rvalid_o=1, a_rdata_o=0xDEADBEEF, b_rvalid_o=0.
- CPU_PRIO=1, MAX_WAIT=4, both requesting continuously → grant sequence A,A,A,A,B,A,A,A,A,B…; b_wait returns to 0 after each B grant; a_stall_o=1 exactly on the B-grant cycles.
- CPU_PRIO=0, both requesting continuously from reset → A,B,A,B…; owner_o toggles every cycle; each rvalid pulses on the cycle after its grant.
- B lock burst: B writes 0x0,0x4,0x8 with b_lock_i=1 on all three, then drops lock; A requesting throughout → no a_gnt_o while locked_o=1; locked_o falls one cycle after b_lock_i=0; A granted in the first ARB cycle; memory contents are the three B words.
- Reset mid-lock: assert reset=0 asynchronously in LOCK_B with a read pending → locked_o, all gnt and rvalid outputs 0 immediately; after reset=1 with both requesting in CPU_PRIO=0 → A granted first.
- Idle/write: a_req_i=1, a_we_i=1, a_wdata_i=0x12345678 → mem_we_o=1 with that data; no rvalid next cycle; with no requests, mem_en_o=0 and owner_o holds.
